// File: rtl/pong_pkg.sv
// Shared screen geometry, colour codes and serve position for the pong pixel,
// score and text stages.
package pong_pkg;

    localparam int MAX_X    = 640;
    localparam int MAX_Y    = 480;
    localparam int REFR_ROW = 481;

    typedef logic [2:0] rgb_t;

    localparam rgb_t C_BLANK = 3'b000;
    localparam rgb_t C_WALL  = 3'b001;
    localparam rgb_t C_BAR   = 3'b010;
    localparam rgb_t C_BALL  = 3'b100;
    localparam rgb_t C_BG    = 3'b110;

    localparam logic [9:0] BALL_X_RST = 10'd316;
    localparam logic [9:0] BALL_Y_RST = 10'd236;
    localparam logic [9:0] BAR_Y_RST  = 10'd204;

endpackage

// File: rtl/pong_ball_rom.sv
// Combinational 8x8 round-ball bitmap; bit n of a row is column n of the ball.
module pong_ball_rom (
    input  logic [2:0] i_row,
    output logic [7:0] o_bits
);

    always_comb begin
        case (i_row)
            3'd0:    o_bits = 8'b0011_1100;
            3'd1:    o_bits = 8'b0111_1110;
            3'd2:    o_bits = 8'b1111_1111;
            3'd3:    o_bits = 8'b1111_1111;
            3'd4:    o_bits = 8'b1111_1111;
            3'd5:    o_bits = 8'b1111_1111;
            3'd6:    o_bits = 8'b0111_1110;
            default: o_bits = 8'b0011_1100;
        endcase
    end

endmodule

// File: rtl/pong_graph_anim.sv
// Pong pixel stage: animates wall, paddle and ball once per frame and produces
// registered RGB plus hit/miss pulses for the game-control logic.
module pong_graph_anim
    import pong_pkg::*;
#(
    parameter int WALL_X_L   = 32,
    parameter int WALL_X_R   = 35,
    parameter int BAR_X_L    = 600,
    parameter int BAR_X_R    = 603,
    parameter int BAR_Y_SIZE = 72,
    parameter int BAR_V      = 4,
    parameter int BALL_SIZE  = 8,
    parameter int BALL_V     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_p_tick,
    input  logic       i_video_on,
    input  logic [9:0] i_pixel_x,
    input  logic [9:0] i_pixel_y,
    input  logic [1:0] i_btn,
    input  logic       i_gra_still,
    output logic       o_graph_on,
    output logic       o_hit,
    output logic       o_miss,
    output logic [2:0] o_rgb
);

    localparam logic [9:0] L_WALL_X_L  = 10'(WALL_X_L);
    localparam logic [9:0] L_WALL_X_R  = 10'(WALL_X_R);
    localparam logic [9:0] L_BAR_X_L   = 10'(BAR_X_L);
    localparam logic [9:0] L_BAR_X_R   = 10'(BAR_X_R);
    localparam logic [9:0] L_BAR_Y_M1  = 10'(BAR_Y_SIZE - 1);
    localparam logic [9:0] L_BAR_V     = 10'(BAR_V);
    localparam logic [9:0] L_BAR_LIMIT = 10'(MAX_Y - 1 - BAR_V);
    localparam logic [9:0] L_BALL_M1   = 10'(BALL_SIZE - 1);
    localparam logic [9:0] L_V_POS     = 10'(BALL_V);
    localparam logic [9:0] L_V_NEG     = 10'(-BALL_V);
    localparam logic [9:0] L_BOTTOM    = 10'(MAX_Y - 2);
    localparam logic [9:0] L_MAX_X     = 10'(MAX_X);
    localparam logic [9:0] L_REFR_ROW  = 10'(REFR_ROW);

    logic [9:0] r_bar_y_t, r_ball_x_l, r_ball_y_t, r_x_delta, r_y_delta;
    logic       r_hit, r_miss;
    rgb_t       r_rgb;

    logic [9:0] w_bar_y_b, w_ball_x_r, w_ball_y_b;
    logic [9:0] w_bar_y_next, w_ball_x_next, w_ball_y_next, w_x_delta_next, w_y_delta_next;
    logic       w_hit, w_miss, w_refr_tick;
    logic       w_wall_on, w_bar_on, w_ball_box, w_ball_on;
    logic [2:0] w_rom_row, w_rom_col;
    logic [7:0] w_rom_bits;
    rgb_t       w_rgb;

    assign w_bar_y_b   = r_bar_y_t + L_BAR_Y_M1;
    assign w_ball_x_r  = r_ball_x_l + L_BALL_M1;
    assign w_ball_y_b  = r_ball_y_t + L_BALL_M1;
    assign w_refr_tick = i_p_tick && (i_pixel_y == L_REFR_ROW) && (i_pixel_x == 10'd0);

    // Next-frame state, evaluated from the positions shown during the frame just drawn
    always_comb begin
        w_bar_y_next = r_bar_y_t;
        if (i_btn == 2'b10 && r_bar_y_t > L_BAR_V)
            w_bar_y_next = r_bar_y_t - L_BAR_V;
        else if (i_btn == 2'b01 && w_bar_y_b < L_BAR_LIMIT)
            w_bar_y_next = r_bar_y_t + L_BAR_V;

        w_ball_x_next  = r_ball_x_l + r_x_delta;
        w_ball_y_next  = r_ball_y_t + r_y_delta;
        w_x_delta_next = r_x_delta;
        w_y_delta_next = r_y_delta;
        w_hit          = 1'b0;
        w_miss         = 1'b0;

        if (r_ball_y_t <= 10'd1)
            w_y_delta_next = L_V_POS;
        else if (w_ball_y_b >= L_BOTTOM)
            w_y_delta_next = L_V_NEG;

        if (r_ball_x_l <= L_WALL_X_R)
            w_x_delta_next = L_V_POS;
        else if (w_ball_x_r >= L_BAR_X_L && w_ball_x_r <= L_BAR_X_R &&
                 w_ball_y_b >= r_bar_y_t && r_ball_y_t <= w_bar_y_b) begin
            w_x_delta_next = L_V_NEG;
            w_hit          = 1'b1;
        end

        // Serve hold and a missed ball both re-centre the ball with fresh deltas
        if (i_gra_still || w_ball_x_r >= L_MAX_X) begin
            w_miss         = !i_gra_still;
            w_hit          = 1'b0;
            w_ball_x_next  = BALL_X_RST;
            w_ball_y_next  = BALL_Y_RST;
            w_x_delta_next = L_V_POS;
            w_y_delta_next = L_V_POS;
        end
    end

    pong_ball_rom u_ball_rom (
        .i_row  (w_rom_row),
        .o_bits (w_rom_bits)
    );

    assign w_rom_row  = i_pixel_y[2:0] - r_ball_y_t[2:0];
    assign w_rom_col  = i_pixel_x[2:0] - r_ball_x_l[2:0];
    assign w_wall_on  = (i_pixel_x >= L_WALL_X_L) && (i_pixel_x <= L_WALL_X_R);
    assign w_bar_on   = (i_pixel_x >= L_BAR_X_L) && (i_pixel_x <= L_BAR_X_R) &&
                        (i_pixel_y >= r_bar_y_t) && (i_pixel_y <= w_bar_y_b);
    assign w_ball_box = (i_pixel_x >= r_ball_x_l) && (i_pixel_x <= w_ball_x_r) &&
                        (i_pixel_y >= r_ball_y_t) && (i_pixel_y <= w_ball_y_b);
    assign w_ball_on  = w_ball_box && w_rom_bits[w_rom_col];
    assign o_graph_on = w_wall_on || w_bar_on || w_ball_on;

    always_comb begin
        if (!i_video_on)     w_rgb = C_BLANK;
        else if (w_wall_on)  w_rgb = C_WALL;
        else if (w_bar_on)   w_rgb = C_BAR;
        else if (w_ball_on)  w_rgb = C_BALL;
        else                 w_rgb = C_BG;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bar_y_t  <= BAR_Y_RST;
            r_ball_x_l <= BALL_X_RST;
            r_ball_y_t <= BALL_Y_RST;
            r_x_delta  <= L_V_POS;
            r_y_delta  <= L_V_POS;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_rgb      <= C_BLANK;
        end else begin
            if (w_refr_tick) begin
                r_bar_y_t  <= w_bar_y_next;
                r_ball_x_l <= w_ball_x_next;
                r_ball_y_t <= w_ball_y_next;
                r_x_delta  <= w_x_delta_next;
                r_y_delta  <= w_y_delta_next;
                r_hit      <= w_hit;
                r_miss     <= w_miss;
            end else begin
                r_hit      <= 1'b0;
                r_miss     <= 1'b0;
            end
            if (i_p_tick)
                r_rgb <= w_rgb;
        end
    end

    assign o_hit  = r_hit;
    assign o_miss = r_miss;
    assign o_rgb  = r_rgb;

endmodule

// File: tb/tb_pong_graph_anim.sv
// Directed bench for pong_graph_anim: frames are compressed to the refresh-tick
// pixel so that hundreds of ball moves fit in a short run.
module tb_pong_graph_anim;

    logic       clk, reset, p_tick, video_on, gra_still;
    logic [9:0] pixel_x, pixel_y;
    logic [1:0] btn;
    logic       graph_on, hit, miss;
    logic [2:0] rgb;

    int   errors = 0;
    int   checks = 0;
    logic fh, fm, fh2, fm2;

    pong_graph_anim dut (
        .clk        (clk),
        .reset      (reset),
        .i_p_tick   (p_tick),
        .i_video_on (video_on),
        .i_pixel_x  (pixel_x),
        .i_pixel_y  (pixel_y),
        .i_btn      (btn),
        .i_gra_still(gra_still),
        .o_graph_on (graph_on),
        .o_hit      (hit),
        .o_miss     (miss),
        .o_rgb      (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One animation frame: the refresh pixel clock, then one idle clock
    task automatic frame();
        pixel_x = 10'd0; pixel_y = 10'd481; video_on = 1'b0; p_tick = 1'b1;
        @(posedge clk); #1;
        fh = hit; fm = miss;
        p_tick = 1'b0; pixel_y = 10'd0;
        @(posedge clk); #1;
        fh2 = hit; fm2 = miss;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn = 2'b00; gra_still = 1'b0; p_tick = 1'b0;
        video_on = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        btn = 2'b01;
        frame();
        btn = 2'b00;
        checks++;
        if (dut.r_bar_y_t !== 10'd208) begin errors++; $display("FAIL pre_reset_bar got=%0d exp=208", dut.r_bar_y_t); end
        pixel_x = 10'd100; pixel_y = 10'd100; video_on = 1'b1; p_tick = 1'b1;
        @(posedge clk); #1;
        p_tick = 1'b0;
        checks++;
        if (rgb !== 3'b110) begin errors++; $display("FAIL pre_reset_rgb got=%b exp=110", rgb); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb got=%b exp=000", rgb); end
        checks++;
        if (dut.r_bar_y_t !== 10'd204) begin errors++; $display("FAIL reset_bar got=%0d exp=204", dut.r_bar_y_t); end
        checks++;
        if (dut.r_ball_x_l !== 10'd316 || dut.r_ball_y_t !== 10'd236) begin
            errors++; $display("FAIL reset_ball got=(%0d,%0d) exp=(316,236)", dut.r_ball_x_l, dut.r_ball_y_t);
        end
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", hit, miss); end
        @(posedge clk); #1 reset = 1'b0;
        frame();
        checks++;
        if (dut.r_ball_x_l !== 10'd318 || dut.r_ball_y_t !== 10'd238) begin
            errors++; $display("FAIL first_move got=(%0d,%0d) exp=(318,238)", dut.r_ball_x_l, dut.r_ball_y_t);
        end
    endtask

    task automatic test_paddle();
        logic [9:0] exp;
        btn = 2'b10;
        for (int i = 1; i <= 60; i++) begin
            frame();
            exp = (i <= 50) ? 10'(204 - 4 * i) : 10'd4;
            checks++;
            if (dut.r_bar_y_t !== exp) begin
                errors++; $display("FAIL paddle_up frame=%0d got=%0d exp=%0d", i, dut.r_bar_y_t, exp);
            end
        end
        btn = 2'b11;
        frame();
        btn = 2'b00;
        checks++;
        if (dut.r_bar_y_t !== 10'd4) begin errors++; $display("FAIL paddle_both got=%0d exp=4", dut.r_bar_y_t); end
        checks++;
        if (dut.r_ball_x_l !== 10'd440 || dut.r_ball_y_t !== 10'd360) begin
            errors++; $display("FAIL ball_tick62 got=(%0d,%0d) exp=(440,360)", dut.r_ball_x_l, dut.r_ball_y_t);
        end
    endtask

    task automatic test_bounce_miss();
        int pulses = 0;
        for (int n = 63; n <= 159; n++) begin
            if (n == 119) begin
                checks++;
                if (dut.r_y_delta !== 10'd2) begin errors++; $display("FAIL ydelta_pre got=%0d exp=2", dut.r_y_delta); end
            end
            frame();
            if (fh || fm || fh2 || fm2) pulses++;
            if (n == 119) begin
                checks++;
                if (dut.r_y_delta !== 10'h3FE || dut.r_ball_y_t !== 10'd474) begin
                    errors++; $display("FAIL bottom_bounce got=(%0d,%0d) exp=(1022,474)", dut.r_y_delta, dut.r_ball_y_t);
                end
            end
            if (n == 140) begin
                checks++;
                if (dut.r_x_delta !== 10'd2) begin errors++; $display("FAIL no_hit_xdelta got=%0d exp=2", dut.r_x_delta); end
            end
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL roundA_pulses got=%0d exp=0", pulses); end
        checks++;
        if (dut.r_ball_x_l !== 10'd634) begin errors++; $display("FAIL pre_miss_x got=%0d exp=634", dut.r_ball_x_l); end
        frame();
        checks++;
        if (fm !== 1'b1 || fm2 !== 1'b0 || fh !== 1'b0) begin
            errors++; $display("FAIL miss_pulse got=%b%b hit=%b exp=10 hit=0", fm, fm2, fh);
        end
        checks++;
        if (dut.r_ball_x_l !== 10'd316 || dut.r_ball_y_t !== 10'd236 ||
            dut.r_x_delta !== 10'd2 || dut.r_y_delta !== 10'd2) begin
            errors++; $display("FAIL miss_reload got=(%0d,%0d,%0d,%0d) exp=(316,236,2,2)",
                               dut.r_ball_x_l, dut.r_ball_y_t, dut.r_x_delta, dut.r_y_delta);
        end
    endtask

    task automatic test_hit_wall();
        int misses = 0;
        for (int m = 1; m <= 422; m++) begin
            btn = (m <= 90) ? 2'b01 : 2'b00;
            frame();
            if (fm || fm2) misses++;
            if (m == 90) begin
                checks++;
                if (dut.r_bar_y_t !== 10'd364) begin errors++; $display("FAIL paddle_down got=%0d exp=364", dut.r_bar_y_t); end
            end
            if (m == 139) begin
                checks++;
                if (fh !== 1'b0) begin errors++; $display("FAIL early_hit got=%b exp=0", fh); end
            end
            if (m == 140) begin
                checks++;
                if (fh !== 1'b1 || fh2 !== 1'b0) begin errors++; $display("FAIL hit_pulse got=%b%b exp=10", fh, fh2); end
                checks++;
                if (dut.r_x_delta !== 10'h3FE) begin errors++; $display("FAIL hit_xdelta got=%0d exp=1022", dut.r_x_delta); end
            end
            if (m == 356) begin
                checks++;
                if (dut.r_y_delta !== 10'h3FE || dut.r_ball_y_t !== 10'd0) begin
                    errors++; $display("FAIL pre_top got=(%0d,%0d) exp=(1022,0)", dut.r_y_delta, dut.r_ball_y_t);
                end
            end
            if (m == 357) begin
                checks++;
                if (dut.r_y_delta !== 10'd2 || dut.r_ball_y_t !== 10'd1022) begin
                    errors++; $display("FAIL top_bounce got=(%0d,%0d) exp=(2,1022)", dut.r_y_delta, dut.r_ball_y_t);
                end
            end
            if (m == 421) begin
                checks++;
                if (dut.r_x_delta !== 10'h3FE || dut.r_ball_x_l !== 10'd34) begin
                    errors++; $display("FAIL pre_wall got=(%0d,%0d) exp=(1022,34)", dut.r_x_delta, dut.r_ball_x_l);
                end
            end
            if (m == 422) begin
                checks++;
                if (dut.r_x_delta !== 10'd2 || dut.r_ball_x_l !== 10'd32) begin
                    errors++; $display("FAIL wall_bounce got=(%0d,%0d) exp=(2,32)", dut.r_x_delta, dut.r_ball_x_l);
                end
            end
        end
        checks++;
        if (misses !== 0) begin errors++; $display("FAIL roundB_miss got=%0d exp=0", misses); end
    endtask

    task automatic test_still();
        int pulses = 0;
        int moved = 0;
        gra_still = 1'b1;
        btn = 2'b10;
        for (int i = 0; i < 5; i++) begin
            frame();
            if (fh || fm || fh2 || fm2) pulses++;
            if (dut.r_ball_x_l !== 10'd316 || dut.r_ball_y_t !== 10'd236) moved++;
        end
        btn = 2'b00;
        checks++;
        if (moved !== 0) begin errors++; $display("FAIL still_ball got=%0d moved frames exp=0", moved); end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL still_pulses got=%0d exp=0", pulses); end
        checks++;
        if (dut.r_bar_y_t !== 10'd344) begin errors++; $display("FAIL still_paddle got=%0d exp=344", dut.r_bar_y_t); end
    endtask

    task automatic test_pixels();
        logic [9:0] px [8];
        logic [9:0] py [8];
        logic       vo [8];
        logic       g  [8];
        logic [2:0] c  [8];
        px[0] = 10'd33;  py[0] = 10'd100; vo[0] = 1'b1; g[0] = 1'b1; c[0] = 3'b001;
        px[1] = 10'd601; py[1] = 10'd344; vo[1] = 1'b1; g[1] = 1'b1; c[1] = 3'b010;
        px[2] = 10'd600; py[2] = 10'd343; vo[2] = 1'b1; g[2] = 1'b0; c[2] = 3'b110;
        px[3] = 10'd316; py[3] = 10'd236; vo[3] = 1'b1; g[3] = 1'b0; c[3] = 3'b110;
        px[4] = 10'd319; py[4] = 10'd239; vo[4] = 1'b1; g[4] = 1'b1; c[4] = 3'b100;
        px[5] = 10'd323; py[5] = 10'd238; vo[5] = 1'b1; g[5] = 1'b1; c[5] = 3'b100;
        px[6] = 10'd324; py[6] = 10'd239; vo[6] = 1'b1; g[6] = 1'b0; c[6] = 3'b110;
        px[7] = 10'd33;  py[7] = 10'd100; vo[7] = 1'b0; g[7] = 1'b1; c[7] = 3'b000;
        for (int k = 0; k < 8; k++) begin
            pixel_x = px[k]; pixel_y = py[k]; video_on = vo[k]; p_tick = 1'b1;
            #1;
            checks++;
            if (graph_on !== g[k]) begin errors++; $display("FAIL graph_on vec=%0d got=%b exp=%b", k, graph_on, g[k]); end
            @(posedge clk); #1;
            checks++;
            if (rgb !== c[k]) begin errors++; $display("FAIL rgb vec=%0d got=%b exp=%b", k, rgb, c[k]); end
        end
        pixel_x = 10'd319; pixel_y = 10'd239; video_on = 1'b1; p_tick = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rgb !== 3'b000) begin errors++; $display("FAIL rgb_hold got=%b exp=000", rgb); end
    endtask

    initial begin
        test_reset();
        test_paddle();
        test_bounce_miss();
        test_hit_wall();
        test_still();
        test_pixels();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
